// File: rtl/tour_cmd_seq.sv
// ============================================================================
// tour_cmd_seq
// ----------------------------------------------------------------------------
// Replays a stored knight's tour to cmd_proc. When TourLogic pulses start_tour
// the sequencer takes the command path away from the UART wrapper (usurp=1).
// It then walks the move table one index at a time. Each knight move is split
// into two straight-line legs, and each leg is issued to cmd_proc as one
// command.
//
// Every command is 16 bits:
//   [15:12] opcode   4'b0010 = move, 4'b0011 = move followed by fanfare
//   [11:4]  heading  +y 8'h00, -y 8'h7F, -x 8'h3F, +x 8'hBF
//   [3:0]   squares  1 or 2
//
// Parameters:
//   NUM_MOVES    number of moves replayed per tour (1..63)
//   IDX_W        width of mv_indx; 2**IDX_W must exceed NUM_MOVES
//   X_FIRST      0: y leg first, then x leg; 1: x leg first, then y leg
//   FANFARE_ALL  0: fanfare only on the 2nd leg of the last move;
//                1: fanfare on every 2nd leg
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start_tour         1-cycle pulse; move table valid, begin replay
//   abort              level; stops the replay on the next edge
//   move               one-hot move at mv_indx
//   mv_indx            index of the move being replayed
//   cmd_UART           command from the UART wrapper
//   cmd_rdy_UART       valid for the UART command
//   clr_cmd_rdy        cmd_proc consumed the current command
//   send_resp          1-cycle pulse; cmd_proc finished the current command
//   cmd, cmd_rdy       muxed command and valid to cmd_proc
//   clr_cmd_rdy_UART   consume strobe to the UART wrapper
//   usurp              1 while the sequencer owns the command path
//   resp               5A while usurping, A5 when idle, E7 after a bad move
//   tour_err           1-cycle pulse when an illegal move is found
// ============================================================================
module tour_cmd_seq #(
    parameter int NUM_MOVES   = 24,
    parameter int IDX_W       = 6,
    parameter int X_FIRST     = 0,
    parameter int FANFARE_ALL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic             abort,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic             clr_cmd_rdy_UART,
    output logic             usurp,
    output logic [7:0]       resp,
    output logic             tour_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    localparam logic [3:0] OP_MOVE    = 4'b0010;
    localparam logic [3:0] OP_FANFARE = 4'b0011;

    localparam logic [7:0] HEAD_POS_Y = 8'h00;
    localparam logic [7:0] HEAD_NEG_Y = 8'h7F;
    localparam logic [7:0] HEAD_NEG_X = 8'h3F;
    localparam logic [7:0] HEAD_POS_X = 8'hBF;

    localparam logic [7:0] RESP_USURP = 8'h5A;
    localparam logic [7:0] RESP_IDLE  = 8'hA5;
    localparam logic [7:0] RESP_ERR   = 8'hE7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEG1  = 3'd1,
        WAIT1 = 3'd2,
        LEG2  = 3'd3,
        WAIT2 = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] cmd_reg;
    logic        cmd_rdy_reg;
    logic        err;

    // Decoded move: direction and length of each axis, plus legality.
    logic        x_neg;
    logic        x_two;
    logic        y_neg;
    logic        y_two;
    logic        move_legal;
    logic [11:0] x_body;
    logic [11:0] y_body;
    logic [11:0] leg1_body;
    logic [11:0] leg2_body;
    logic [3:0]  leg2_op;
    logic        last_move;

    // Split the one-hot knight move into its x and y parts.
    // Any pattern other than a single set bit is illegal and traps the tour.
    always_comb begin
        x_neg      = 1'b0;
        x_two      = 1'b0;
        y_neg      = 1'b0;
        y_two      = 1'b0;
        move_legal = 1'b1;
        case (move)
            8'h01: begin x_neg = 1'b0; x_two = 1'b0; y_neg = 1'b0; y_two = 1'b1; end
            8'h02: begin x_neg = 1'b1; x_two = 1'b0; y_neg = 1'b0; y_two = 1'b1; end
            8'h04: begin x_neg = 1'b1; x_two = 1'b1; y_neg = 1'b0; y_two = 1'b0; end
            8'h08: begin x_neg = 1'b1; x_two = 1'b1; y_neg = 1'b1; y_two = 1'b0; end
            8'h10: begin x_neg = 1'b1; x_two = 1'b0; y_neg = 1'b1; y_two = 1'b1; end
            8'h20: begin x_neg = 1'b0; x_two = 1'b0; y_neg = 1'b1; y_two = 1'b1; end
            8'h40: begin x_neg = 1'b0; x_two = 1'b1; y_neg = 1'b1; y_two = 1'b0; end
            8'h80: begin x_neg = 1'b0; x_two = 1'b1; y_neg = 1'b0; y_two = 1'b0; end
            default: move_legal = 1'b0;
        endcase
    end

    // Build the heading and square count for each axis, then order the legs.
    // The fanfare opcode is only ever placed on the second leg, so the robot
    // celebrates after it has finished the whole knight move.
    always_comb begin
        x_body    = {(x_neg ? HEAD_NEG_X : HEAD_POS_X), (x_two ? 4'd2 : 4'd1)};
        y_body    = {(y_neg ? HEAD_NEG_Y : HEAD_POS_Y), (y_two ? 4'd2 : 4'd1)};
        leg1_body = (X_FIRST != 0) ? x_body : y_body;
        leg2_body = (X_FIRST != 0) ? y_body : x_body;
        last_move = (mv_indx == LAST_IDX);
        leg2_op   = ((FANFARE_ALL != 0) || last_move) ? OP_FANFARE : OP_MOVE;
    end

    // Sequencer state machine.
    // Each LEG state loads its command on the first cycle it is entered;
    // cmd_rdy_reg is always low on entry, so it marks that first cycle.
    // The state then holds until cmd_proc consumes the command.
    // A send_resp that arrives together with clr_cmd_rdy is deliberately
    // dropped, so the WAIT state needs its own send_resp. abort is checked
    // before anything else. It returns to IDLE but leaves mv_indx alone so
    // software can see where the tour stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mv_indx     <= '0;
            usurp       <= 1'b0;
            cmd_reg     <= 16'h0000;
            cmd_rdy_reg <= 1'b0;
            tour_err    <= 1'b0;
            err         <= 1'b0;
        end else begin
            tour_err <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                cmd_rdy_reg <= 1'b0;
                usurp       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        usurp <= 1'b0;
                        if (start_tour) begin
                            mv_indx     <= '0;
                            usurp       <= 1'b1;
                            err         <= 1'b0;
                            cmd_rdy_reg <= 1'b0;
                            state       <= LEG1;
                        end
                    end
                    LEG1: begin
                        if (!cmd_rdy_reg) begin
                            if (!move_legal) begin
                                tour_err <= 1'b1;
                                err      <= 1'b1;
                                usurp    <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                cmd_reg     <= {OP_MOVE, leg1_body};
                                cmd_rdy_reg <= 1'b1;
                            end
                        end else if (clr_cmd_rdy) begin
                            cmd_rdy_reg <= 1'b0;
                            state       <= WAIT1;
                        end
                    end
                    WAIT1: begin
                        if (send_resp) begin
                            state <= LEG2;
                        end
                    end
                    LEG2: begin
                        if (!cmd_rdy_reg) begin
                            cmd_reg     <= {leg2_op, leg2_body};
                            cmd_rdy_reg <= 1'b1;
                        end else if (clr_cmd_rdy) begin
                            cmd_rdy_reg <= 1'b0;
                            state       <= WAIT2;
                        end
                    end
                    WAIT2: begin
                        if (send_resp) begin
                            if (last_move) begin
                                usurp <= 1'b0;
                                state <= IDLE;
                            end else begin
                                mv_indx <= mv_indx + 1'b1;
                                state   <= LEG1;
                            end
                        end
                    end
                    default: begin
                        cmd_rdy_reg <= 1'b0;
                        usurp       <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

    // Command path mux. While the sequencer owns the path, the UART wrapper
    // must not see cmd_proc's consume strobe, or it would drop a queued command.
    always_comb begin
        cmd              = usurp ? cmd_reg : cmd_UART;
        cmd_rdy          = usurp ? cmd_rdy_reg : cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy & ~usurp;
    end

    // The error response takes priority so a trapped tour stays visible
    // until the next start_tour.
    always_comb begin
        if (err) begin
            resp = RESP_ERR;
        end else if (usurp) begin
            resp = RESP_USURP;
        end else begin
            resp = RESP_IDLE;
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq.
// Three instances cover the parameter sets of interest:
//   u0: defaults (24 moves, y leg first, fanfare only on the last move)
//   u1: NUM_MOVES=2
//   u2: NUM_MOVES=1, X_FIRST=1
// Each instance takes its moves from its own table, indexed by its own mv_indx.
// The remaining inputs are shared, and an idle instance ignores them.
module tb_tour_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;

    logic        start0, start1, start2;
    logic [7:0]  move0, move1, move2;
    logic [5:0]  mv_indx0, mv_indx1, mv_indx2;
    logic [15:0] cmd0, cmd1, cmd2;
    logic        cmd_rdy0, cmd_rdy1, cmd_rdy2;
    logic        clr_uart0, clr_uart1, clr_uart2;
    logic        usurp0, usurp1, usurp2;
    logic [7:0]  resp0, resp1, resp2;
    logic        tour_err0, tour_err1, tour_err2;

    logic [7:0]  tbl0 [64];
    logic [7:0]  tbl1 [64];
    logic [7:0]  tbl2 [64];

    int checks;
    int failures;

    assign move0 = tbl0[mv_indx0];
    assign move1 = tbl1[mv_indx1];
    assign move2 = tbl2[mv_indx2];

    tour_cmd_seq u0 (
        .clk(clk), .rst_n(rst_n), .start_tour(start0), .abort(abort), .move(move0),
        .mv_indx(mv_indx0), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd0), .cmd_rdy(cmd_rdy0),
        .clr_cmd_rdy_UART(clr_uart0), .usurp(usurp0), .resp(resp0), .tour_err(tour_err0)
    );

    tour_cmd_seq #(.NUM_MOVES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start_tour(start1), .abort(abort), .move(move1),
        .mv_indx(mv_indx1), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd1), .cmd_rdy(cmd_rdy1),
        .clr_cmd_rdy_UART(clr_uart1), .usurp(usurp1), .resp(resp1), .tour_err(tour_err1)
    );

    tour_cmd_seq #(.NUM_MOVES(1), .X_FIRST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start_tour(start2), .abort(abort), .move(move2),
        .mv_indx(mv_indx2), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd2), .cmd_rdy(cmd_rdy2),
        .clr_cmd_rdy_UART(clr_uart2), .usurp(usurp2), .resp(resp2), .tour_err(tour_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consume the current leg, then finish it. Once the next leg is loaded,
    // cmd_rdy is high again.
    task automatic run_leg();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b0;
        tick();
        checks++;
        if (usurp0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_usurp got %b want 0", usurp0); end
        checks++;
        if (resp0 !== 8'hA5) begin failures++; $display("[TB] FAIL reset_resp got %h want a5", resp0); end
        checks++;
        if (mv_indx0 !== 6'd0) begin failures++; $display("[TB] FAIL reset_mv_indx got %0d want 0", mv_indx0); end
        checks++;
        if (tour_err0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_tour_err got %b want 0", tour_err0); end
        checks++;
        if (cmd0 !== 16'h1234) begin failures++; $display("[TB] FAIL reset_cmd got %h want 1234", cmd0); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        cmd_UART = 16'h5C3A;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1;
        #1;
        checks++;
        if (cmd0 !== 16'h5C3A) begin failures++; $display("[TB] FAIL pass_cmd got %h want 5c3a", cmd0); end
        checks++;
        if (cmd_rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL pass_cmd_rdy got %b want 1", cmd_rdy0); end
        checks++;
        if (clr_uart0 !== 1'b1) begin failures++; $display("[TB] FAIL pass_clr_uart got %b want 1", clr_uart0); end
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        checks++;
        if (clr_uart0 !== 1'b0) begin failures++; $display("[TB] FAIL pass_clr_uart_low got %b want 0", clr_uart0); end
        tick();
    endtask

    // Start a default tour: check the first two legs and the step to move 1.
    // Then walk to move 5 and abort there while in WAIT1.
    task automatic test_single_move_and_abort();
        tbl0[0] = 8'h01; tbl0[1] = 8'h02; tbl0[2] = 8'h04;
        tbl0[3] = 8'h10; tbl0[4] = 8'h20; tbl0[5] = 8'h80;
        cmd_UART = 16'hBEEF;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        checks++;
        if (cmd_rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL m0_leg1_rdy got %b want 1", cmd_rdy0); end
        checks++;
        if (cmd0 !== 16'h2002) begin failures++; $display("[TB] FAIL m0_leg1_cmd got %h want 2002", cmd0); end
        checks++;
        if (usurp0 !== 1'b1) begin failures++; $display("[TB] FAIL m0_usurp got %b want 1", usurp0); end
        checks++;
        if (resp0 !== 8'h5A) begin failures++; $display("[TB] FAIL m0_resp got %h want 5a", resp0); end
        clr_cmd_rdy = 1'b1;
        #1;
        checks++;
        if (clr_uart0 !== 1'b0) begin failures++; $display("[TB] FAIL m0_clr_uart_blocked got %b want 0", clr_uart0); end
        tick();
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy0 !== 1'b0) begin failures++; $display("[TB] FAIL m0_wait1_rdy got %b want 0", cmd_rdy0); end
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick();
        checks++;
        if (cmd0 !== 16'h2BF1) begin failures++; $display("[TB] FAIL m0_leg2_cmd got %h want 2bf1", cmd0); end
        run_leg();
        checks++;
        if (mv_indx0 !== 6'd1) begin failures++; $display("[TB] FAIL m1_mv_indx got %0d want 1", mv_indx0); end
        checks++;
        if (cmd0 !== 16'h2002) begin failures++; $display("[TB] FAIL m1_leg1_cmd got %h want 2002", cmd0); end
        run_leg();
        checks++;
        if (cmd0 !== 16'h23F1) begin failures++; $display("[TB] FAIL m1_leg2_cmd got %h want 23f1", cmd0); end
        for (int i = 0; i < 7; i++) run_leg();
        checks++;
        if (mv_indx0 !== 6'd5) begin failures++; $display("[TB] FAIL m5_mv_indx got %0d want 5", mv_indx0); end
        checks++;
        if (cmd0 !== 16'h2001) begin failures++; $display("[TB] FAIL m5_leg1_cmd got %h want 2001", cmd0); end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        abort = 1'b1;
        send_resp = 1'b1;
        tick();
        abort = 1'b0;
        send_resp = 1'b0;
        checks++;
        if (usurp0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_usurp got %b want 0", usurp0); end
        checks++;
        if (mv_indx0 !== 6'd5) begin failures++; $display("[TB] FAIL abort_mv_indx got %0d want 5", mv_indx0); end
        checks++;
        if (cmd0 !== 16'hBEEF) begin failures++; $display("[TB] FAIL abort_cmd_uart got %h want beef", cmd0); end
        checks++;
        if (tour_err0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_tour_err got %b want 0", tour_err0); end
        checks++;
        if (resp0 !== 8'hA5) begin failures++; $display("[TB] FAIL abort_resp got %h want a5", resp0); end
        tick();
        checks++;
        if (usurp0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_stays_idle got %b want 0", usurp0); end
    endtask

    // Two-move tour. clr_cmd_rdy and send_resp arrive together on the first
    // leg, so the bench must supply a second send_resp before leg 2 appears.
    task automatic test_two_moves();
        tbl1[0] = 8'h08; tbl1[1] = 8'h40;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        checks++;
        if (cmd1 !== 16'h27F1) begin failures++; $display("[TB] FAIL t2_m0_leg1 got %h want 27f1", cmd1); end
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        tick();
        tick();
        checks++;
        if (cmd_rdy1 !== 1'b0) begin failures++; $display("[TB] FAIL t2_same_cycle_wait got %b want 0", cmd_rdy1); end
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick();
        checks++;
        if (cmd1 !== 16'h23F2) begin failures++; $display("[TB] FAIL t2_m0_leg2 got %h want 23f2", cmd1); end
        checks++;
        if (mv_indx1 !== 6'd0) begin failures++; $display("[TB] FAIL t2_m0_idx got %0d want 0", mv_indx1); end
        run_leg();
        checks++;
        if (mv_indx1 !== 6'd1) begin failures++; $display("[TB] FAIL t2_m1_idx got %0d want 1", mv_indx1); end
        checks++;
        if (cmd1 !== 16'h27F1) begin failures++; $display("[TB] FAIL t2_m1_leg1 got %h want 27f1", cmd1); end
        run_leg();
        checks++;
        if (cmd1 !== 16'h3BF2) begin failures++; $display("[TB] FAIL t2_m1_leg2 got %h want 3bf2", cmd1); end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        checks++;
        if (usurp1 !== 1'b0) begin failures++; $display("[TB] FAIL t2_end_usurp got %b want 0", usurp1); end
        checks++;
        if (resp1 !== 8'hA5) begin failures++; $display("[TB] FAIL t2_end_resp got %h want a5", resp1); end
        checks++;
        if (mv_indx1 !== 6'd1) begin failures++; $display("[TB] FAIL t2_end_idx got %0d want 1", mv_indx1); end
    endtask

    // X leg first on a one-move tour; a start_tour pulse mid-tour must be ignored.
    task automatic test_x_first();
        tbl2[0] = 8'h80;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        checks++;
        if (cmd2 !== 16'h2BF2) begin failures++; $display("[TB] FAIL xf_leg1 got %h want 2bf2", cmd2); end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick();
        checks++;
        if (cmd2 !== 16'h3001) begin failures++; $display("[TB] FAIL xf_leg2 got %h want 3001", cmd2); end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        checks++;
        if (usurp2 !== 1'b0) begin failures++; $display("[TB] FAIL xf_end_usurp got %b want 0", usurp2); end
    endtask

    task automatic test_illegal();
        tbl0[0] = 8'h03;
        cmd_rdy_UART = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        checks++;
        if (tour_err0 !== 1'b1) begin failures++; $display("[TB] FAIL ill_tour_err got %b want 1", tour_err0); end
        checks++;
        if (usurp0 !== 1'b0) begin failures++; $display("[TB] FAIL ill_usurp got %b want 0", usurp0); end
        checks++;
        if (resp0 !== 8'hE7) begin failures++; $display("[TB] FAIL ill_resp got %h want e7", resp0); end
        checks++;
        if (cmd_rdy0 !== 1'b0) begin failures++; $display("[TB] FAIL ill_cmd_rdy got %b want 0", cmd_rdy0); end
        tick();
        checks++;
        if (tour_err0 !== 1'b0) begin failures++; $display("[TB] FAIL ill_pulse_width got %b want 0", tour_err0); end
        checks++;
        if (resp0 !== 8'hE7) begin failures++; $display("[TB] FAIL ill_resp_hold got %h want e7", resp0); end
        tbl0[0] = 8'h01;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (resp0 !== 8'h5A) begin failures++; $display("[TB] FAIL ill_restart_resp got %h want 5a", resp0); end
    endtask

    // The tour started above is still running; pull reset in mid-cycle.
    task automatic test_async_reset();
        tick();
        cmd_UART = 16'h0F0F;
        cmd_rdy_UART = 1'b0;
        checks++;
        if (cmd_rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL ar_pre_rdy got %b want 1", cmd_rdy0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (usurp0 !== 1'b0) begin failures++; $display("[TB] FAIL ar_usurp got %b want 0", usurp0); end
        checks++;
        if (cmd_rdy0 !== 1'b0) begin failures++; $display("[TB] FAIL ar_cmd_rdy got %b want 0", cmd_rdy0); end
        checks++;
        if (cmd0 !== 16'h0F0F) begin failures++; $display("[TB] FAIL ar_cmd got %h want 0f0f", cmd0); end
        checks++;
        if (resp0 !== 8'hA5) begin failures++; $display("[TB] FAIL ar_resp got %h want a5", resp0); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        abort = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tbl0[i] = 8'h01;
            tbl1[i] = 8'h01;
            tbl2[i] = 8'h01;
        end
        test_reset();
        test_passthrough();
        test_single_move_and_abort();
        test_two_moves();
        test_x_first();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
